// File: rtl/bist_log_pkg.sv
// Shared types and constants for the BIST failure log.
// Entry layout depends on BIST_LOG_DATA_EN (address only when undefined).
package bist_log_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_e;

    localparam int DEF_LOG_DEPTH = 4;
    localparam int DEF_CNT_WIDTH = 8;

`ifdef BIST_LOG_DATA_EN
    localparam bit LOG_DATA_EN = 1'b1;
`else
    localparam bit LOG_DATA_EN = 1'b0;
`endif

    // Stored entry is {address, data_exp, data_act} or just {address}.
    function automatic int entry_width(input int ad_w, input int data_w);
        return LOG_DATA_EN ? (ad_w + 2 * data_w) : ad_w;
    endfunction

endpackage

// File: rtl/bist_fail_log_if.sv
// Comparator tap and host readout port of the BIST failure log.
interface bist_fail_log_if #(
    parameter int data_width = 4,
    parameter int ad_width   = 4
);
    logic                  cmp_valid;
    logic                  is_equal;
    logic [ad_width-1:0]   address;
    logic [data_width-1:0] data_exp;
    logic [data_width-1:0] data_act;
    logic                  rd_en;
    logic                  rd_valid;
    logic [ad_width-1:0]   rd_addr;
    logic [data_width-1:0] rd_exp;
    logic [data_width-1:0] rd_act;

    modport master (
        output cmp_valid, is_equal, address, data_exp, data_act, rd_en,
        input  rd_valid, rd_addr, rd_exp, rd_act
    );

    modport slave (
        input  cmp_valid, is_equal, address, data_exp, data_act, rd_en,
        output rd_valid, rd_addr, rd_exp, rd_act
    );
endinterface

// File: rtl/bist_log_fifo.sv
// Synchronous FIFO with flush and same-cycle push+pop; pointers carry one
// extra wrap bit so full/empty come from an MSB compare.
module bist_log_fifo #(
    parameter int ENTRY_W = 4,
    parameter int DEPTH   = 4
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               flush_i,
    input  logic               push_i,
    input  logic               pop_i,
    input  logic [ENTRY_W-1:0] wdata_i,
    output logic [ENTRY_W-1:0] rdata_o,
    output logic               full_o,
    output logic               empty_o
);
    localparam int AW = $clog2(DEPTH);

    logic [AW:0]        wp_q, rp_q;
    logic [ENTRY_W-1:0] mem_q [DEPTH];
    logic               do_push, do_pop;

    assign empty_o = (wp_q == rp_q);
    assign full_o  = (wp_q[AW] != rp_q[AW]) && (wp_q[AW-1:0] == rp_q[AW-1:0]);

    // A push into a full FIFO is only legal when the head leaves this cycle.
    assign do_pop  = pop_i && !empty_o && !flush_i;
    assign do_push = push_i && (!full_o || do_pop) && !flush_i;

    assign rdata_o = mem_q[rp_q[AW-1:0]];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wp_q <= '0;
            rp_q <= '0;
        end else if (flush_i) begin
            wp_q <= '0;
            rp_q <= '0;
        end else begin
            if (do_push) wp_q <= wp_q + (AW+1)'(1);
            if (do_pop)  rp_q <= rp_q + (AW+1)'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem_q[wp_q[AW-1:0]] <= wdata_i;
    end
endmodule

// File: rtl/bist_fail_log.sv
// BIST failure capture: logs mismatching reads into a FIFO, keeps a
// saturating fail count and sticky overflow. Data logging via BIST_LOG_DATA_EN.
module bist_fail_log
    import bist_log_pkg::*;
#(
    parameter int data_width = 4,
    parameter int ad_width   = 4,
    parameter int log_depth  = DEF_LOG_DEPTH,
    parameter int cnt_width  = DEF_CNT_WIDTH
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic                 done,
    bist_fail_log_if.slave       bus,
    output logic                 log_empty,
    output logic                 log_full,
    output logic [cnt_width-1:0] fail_count,
    output logic                 overflow,
    output logic                 busy
);
    localparam int ENTRY_W = entry_width(ad_width, data_width);

    state_e               state_q;
    logic                 busy_q;
    logic [cnt_width-1:0] cnt_q, cnt_d;
    logic                 ovf_q, ovf_d;
    logic                 rd_valid_q;
    logic [ENTRY_W-1:0]   rd_entry_q;

    logic               running, accept_start, capture, pop_ok, drop;
    logic               fifo_full, fifo_empty;
    logic [ENTRY_W-1:0] push_entry, head_entry;

    assign running      = (state_q == ST_RUN);
    assign accept_start = start && !running;
    assign capture      = running && bus.cmp_valid && !bus.is_equal;
    // Flush wins over a same-cycle pop, so the pop is simply discarded.
    assign pop_ok       = bus.rd_en && !fifo_empty && !accept_start;
    assign drop         = capture && fifo_full && !pop_ok;

    bist_log_fifo #(
        .ENTRY_W (ENTRY_W),
        .DEPTH   (log_depth)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .flush_i (accept_start),
        .push_i  (capture),
        .pop_i   (pop_ok),
        .wdata_i (push_entry),
        .rdata_o (head_entry),
        .full_o  (fifo_full),
        .empty_o (fifo_empty)
    );

    always_comb begin
        cnt_d = cnt_q;
        ovf_d = ovf_q;
        if (accept_start) begin
            cnt_d = '0;
            ovf_d = 1'b0;
        end else begin
            if (capture && (cnt_q != {cnt_width{1'b1}})) cnt_d = cnt_q + cnt_width'(1);
            if (drop) ovf_d = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            busy_q     <= 1'b0;
            cnt_q      <= '0;
            ovf_q      <= 1'b0;
            rd_valid_q <= 1'b0;
            rd_entry_q <= '0;
        end else begin
            case (state_q)
                ST_RUN: begin
                    if (done) begin
                        state_q <= ST_DONE;
                        busy_q  <= 1'b0;
                    end
                end
                default: begin
                    if (start) begin
                        state_q <= ST_RUN;
                        busy_q  <= 1'b1;
                    end
                end
            endcase
            cnt_q      <= cnt_d;
            ovf_q      <= ovf_d;
            rd_valid_q <= pop_ok;
            if (pop_ok) rd_entry_q <= head_entry;
        end
    end

`ifdef BIST_LOG_DATA_EN
    assign push_entry  = {bus.address, bus.data_exp, bus.data_act};
    assign bus.rd_addr = rd_entry_q[ENTRY_W-1 -: ad_width];
    assign bus.rd_exp  = rd_entry_q[2*data_width-1 -: data_width];
    assign bus.rd_act  = rd_entry_q[data_width-1:0];
`else
    logic unused_data;
    assign unused_data = ^{bus.data_exp, bus.data_act};
    assign push_entry  = bus.address;
    assign bus.rd_addr = rd_entry_q;
    assign bus.rd_exp  = '0;
    assign bus.rd_act  = '0;
`endif

    assign bus.rd_valid = rd_valid_q;
    assign log_empty    = fifo_empty;
    assign log_full     = fifo_full;
    assign fail_count   = cnt_q;
    assign overflow     = ovf_q;
    assign busy         = busy_q;
endmodule

// File: tb/tb_bist_fail_log.sv
// Randomized bench for bist_fail_log against a queue-based reference model.
module tb_bist_fail_log;
    localparam int DW    = 4;
    localparam int AWD   = 4;
    localparam int DEPTH = 4;
    localparam int CW    = 3;
    localparam int CMAX  = (1 << CW) - 1;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic start = 1'b0;
    logic done = 1'b0;
    logic log_empty, log_full, overflow, busy;
    logic [CW-1:0] fail_count;

    bist_fail_log_if #(.data_width(DW), .ad_width(AWD)) bus ();

    bist_fail_log #(
        .data_width (DW),
        .ad_width   (AWD),
        .log_depth  (DEPTH),
        .cnt_width  (CW)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .done       (done),
        .bus        (bus),
        .log_empty  (log_empty),
        .log_full   (log_full),
        .fail_count (fail_count),
        .overflow   (overflow),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [AWD-1:0] a;
        logic [DW-1:0]  e;
        logic [DW-1:0]  x;
    } ent_t;

    ent_t mq[$];
    bit   m_run;
    int   m_cnt;
    bit   m_ovf;
    bit   m_rdv;
    ent_t m_rd;

    int n_vec = 0;
    int n_err = 0;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        mq.delete();
        m_run = 0;
        m_cnt = 0;
        m_ovf = 0;
        m_rdv = 0;
        m_rd  = '0;
    endtask

    task automatic check_all();
        check_val("rd_valid",   32'(bus.rd_valid), 32'(m_rdv));
        check_val("rd_addr",    32'(bus.rd_addr),  32'(m_rd.a));
        check_val("rd_exp",     32'(bus.rd_exp),   32'(m_rd.e));
        check_val("rd_act",     32'(bus.rd_act),   32'(m_rd.x));
        check_val("log_empty",  32'(log_empty),    32'(mq.size() == 0));
        check_val("log_full",   32'(log_full),     32'(mq.size() == DEPTH));
        check_val("fail_count", 32'(fail_count),   32'(m_cnt));
        check_val("overflow",   32'(overflow),     32'(m_ovf));
        check_val("busy",       32'(busy),         32'(m_run));
    endtask

    // One clock: drive inputs, advance the model by the stated rules, compare.
    task automatic cycle(input bit st, input bit dn, input bit cv, input bit eq,
                         input logic [AWD-1:0] a, input logic [DW-1:0] e,
                         input logic [DW-1:0] x, input bit rd);
        bit   flush, cap, pop;
        ent_t ne;
        start         = st;
        done          = dn;
        bus.cmp_valid = cv;
        bus.is_equal  = eq;
        bus.address   = a;
        bus.data_exp  = e;
        bus.data_act  = x;
        bus.rd_en     = rd;

        flush = st && !m_run;
        cap   = m_run && cv && !eq;
        pop   = rd && (mq.size() > 0) && !flush;
        if (flush) begin
            mq.delete();
            m_cnt = 0;
            m_ovf = 0;
        end
        m_rdv = pop;
        if (pop) m_rd = mq.pop_front();
        if (cap) begin
            if (m_cnt < CMAX) m_cnt++;
            ne.a = a;
`ifdef BIST_LOG_DATA_EN
            ne.e = e;
            ne.x = x;
`else
            ne.e = '0;
            ne.x = '0;
`endif
            if (mq.size() < DEPTH) mq.push_back(ne);
            else m_ovf = 1;
        end
        if (m_run && dn) m_run = 0;
        else if (!m_run && st) m_run = 1;

        @(posedge clk);
        #1;
        check_all();
    endtask

    task automatic idle();
        cycle(0, 0, 0, 1, '0, '0, '0, 0);
    endtask

    task automatic mis(input logic [AWD-1:0] a, input logic [DW-1:0] e, input logic [DW-1:0] x);
        cycle(0, 0, 1, 0, a, e, x, 0);
    endtask

    task automatic rd_pop();
        cycle(0, 0, 0, 1, '0, '0, '0, 1);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        #2;
        model_reset();
        check_all();
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    initial begin
        bus.cmp_valid = 0;
        bus.is_equal  = 1;
        bus.address   = '0;
        bus.data_exp  = '0;
        bus.data_act  = '0;
        bus.rd_en     = 0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        check_all();
        rst = 1'b0;

        // Three failures, then in-order readout.
        cycle(1, 0, 0, 1, '0, '0, '0, 0);
        mis(4'd2, 4'hA, 4'h8);
        mis(4'd5, 4'h5, 4'h4);
        mis(4'd9, 4'hF, 4'h0);
        cycle(0, 1, 0, 1, '0, '0, '0, 0);
        check_val("cnt_after_3", 32'(fail_count), 32'd3);
        rd_pop();
        check_val("first_addr", 32'(bus.rd_addr), 32'd2);
        idle();
        rd_pop();
        rd_pop();
        check_val("third_addr", 32'(bus.rd_addr), 32'd9);
        idle();

        // Mismatches outside RUN or without cmp_valid are ignored.
        cycle(0, 0, 0, 0, 4'd3, 4'h1, 4'h2, 0);
        mis(4'd4, 4'h1, 4'h2);
        cycle(1, 0, 0, 1, '0, '0, '0, 0);
        cycle(0, 0, 0, 0, 4'd6, 4'h3, 4'h1, 0);
        cycle(1, 0, 0, 1, '0, '0, '0, 0);

        // Six failures into a 4-deep log: full, overflow, first four kept.
        for (int i = 0; i < 6; i++) mis(AWD'(i + 1), DW'(i), DW'(~i));
        check_val("ovf_set", 32'(overflow), 32'd1);
        check_val("full_set", 32'(log_full), 32'd1);
        // Full plus same-cycle pop: stored, no further overflow change.
        cycle(0, 0, 1, 0, 4'hC, 4'h7, 4'h3, 1);
        check_val("pop_oldest", 32'(bus.rd_addr), 32'd1);
        cycle(0, 1, 0, 1, '0, '0, '0, 0);
        for (int i = 0; i < 4; i++) rd_pop();
        rd_pop();

        // Flush beats same-cycle pop; new start clears overflow.
        cycle(1, 0, 1, 0, 4'h1, 4'h1, 4'h0, 0);
        mis(4'h8, 4'h2, 4'h3);
        cycle(0, 1, 0, 1, '0, '0, '0, 0);
        cycle(1, 0, 0, 1, '0, '0, '0, 1);
        check_val("flush_no_rdv", 32'(bus.rd_valid), 32'd0);

        // Saturation and a reset mid-run.
        for (int i = 0; i < 10; i++) cycle(0, 0, 1, 0, AWD'(i), DW'(i), DW'(i + 3), 1);
        check_val("cnt_sat", 32'(fail_count), 32'(CMAX));
        do_reset();

        // Randomized traffic.
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 399) == 0) begin
                do_reset();
            end else begin
                cycle($urandom_range(0, 19) == 0, $urandom_range(0, 24) == 0,
                      $urandom_range(0, 1) == 1, $urandom_range(0, 2) == 0,
                      AWD'($urandom), DW'($urandom), DW'($urandom),
                      $urandom_range(0, 2) == 0);
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
